// File: rtl/zbuf_pkg.sv
// zbuf_pkg: shared types and helpers for the z-buffer depth tester.
//   point_t     - generator point, packed so it maps directly onto the
//                 24-bit generator bus (x in [23:16], y in [15:8], z in [7:0])
//   zt_state_t  - controller state encoding
//   CLEAR_DEPTH_DEFAULT - farthest depth, written by a clear sweep
//   xy_to_addr  - screen coordinate to depth/frame address mapping
package zbuf_pkg;

  localparam logic [7:0] CLEAR_DEPTH_DEFAULT = 8'hFF;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] z;
  } point_t;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    FETCH,
    RD,
    CMP,
    EOC,
    FIN,
    CLR
  } zt_state_t;

  // Row-major layout: y selects the 256-entry row, x the column.
  function automatic logic [15:0] xy_to_addr(input logic [7:0] x, input logic [7:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/zbuf_depth_test.sv
// zbuf_depth_test: pulls points from the 3D Bresenham generator, depth-tests
// each one against an external depth RAM and emits frame-buffer writes for
// points strictly closer than the stored depth. Also sweeps the whole depth
// RAM with CLEAR_DEPTH on request.
// Ports:
//   clk, rst            - clock, synchronous active-low reset
//   start, clear        - one-cycle commands, honoured only when idle
//   color_in            - colour for the line, captured on start
//   busy, done          - activity flag and completion pulse
//   line_init/req/eoc   - generator control outputs
//   line_ack, line_eol  - generator handshake/end-of-line inputs
//   point_in            - generator point {x,y,z}
//   dmem_*              - depth RAM port (read data 1 cycle after rd_en)
//   pix_we/addr/data    - frame-buffer write port
//   pix_count           - saturating count of pixels written for this line
module zbuf_depth_test
  import zbuf_pkg::*;
#(
  parameter int         COLOR_W     = 8,
  parameter logic [7:0] CLEAR_DEPTH = CLEAR_DEPTH_DEFAULT,
  parameter int         ADDR_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               clear,
  input  logic [COLOR_W-1:0] color_in,
  output logic               busy,
  output logic               done,
  output logic               line_init,
  output logic               line_req,
  input  logic               line_ack,
  input  logic               line_eol,
  output logic               line_eoc,
  input  logic [23:0]        point_in,
  output logic [ADDR_W-1:0]  dmem_addr,
  output logic               dmem_rd_en,
  input  logic [7:0]         dmem_rdata,
  output logic               dmem_wr_en,
  output logic [7:0]         dmem_wdata,
  output logic               pix_we,
  output logic [ADDR_W-1:0]  pix_addr,
  output logic [COLOR_W-1:0] pix_data,
  output logic [15:0]        pix_count
);

  zt_state_t          state, next_state;
  point_t             pt;
  logic               eol_seen;
  logic [COLOR_W-1:0] color_q;
  logic [15:0]        clr_cnt;
  logic [ADDR_W-1:0]  pt_addr;
  logic               closer;

  assign pt_addr = ADDR_W'(xy_to_addr(pt.x, pt.y));

  // Strict compare: an equal depth (including the generator's duplicated
  // final point) must never produce a second write.
  assign closer = (pt.z < dmem_rdata);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (clear) next_state = CLR;
               else if (start) next_state = SYNC;
      SYNC:    if (line_ack) next_state = FETCH;
      FETCH:   if (!line_ack) next_state = RD;
      RD:      next_state = CMP;
      CMP:     next_state = eol_seen ? EOC : FETCH;
      EOC:     next_state = FIN;
      FIN:     next_state = IDLE;
      CLR:     if (clr_cnt == 16'hFFFF) next_state = FIN;
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers. line_init is registered so it comes out of a flop
  // for the single cycle following the accepted start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pt        <= '0;
      eol_seen  <= 1'b0;
      color_q   <= '0;
      clr_cnt   <= '0;
      pix_count <= '0;
      line_init <= 1'b0;
    end else begin
      line_init <= (state == IDLE) && start && !clear;
      case (state)
        IDLE: begin
          clr_cnt <= '0;
          if (!clear && start) begin
            color_q   <= color_in;
            pix_count <= '0;
          end
        end
        FETCH: begin
          if (!line_ack) begin
            pt       <= point_t'(point_in);
            eol_seen <= line_eol;
          end
        end
        CMP: begin
          if (closer && (pix_count != 16'hFFFF)) begin
            pix_count <= pix_count + 16'd1;
          end
        end
        CLR: clr_cnt <= clr_cnt + 16'd1;
        default: ;
      endcase
    end
  end

  // All outputs decode from the state register and latched datapath; the
  // only live input in this path is the RAM read data during CMP.
  always_comb begin
    busy       = (state != IDLE);
    done       = 1'b0;
    line_req   = 1'b0;
    line_eoc   = 1'b0;
    dmem_addr  = '0;
    dmem_rd_en = 1'b0;
    dmem_wr_en = 1'b0;
    dmem_wdata = '0;
    pix_we     = 1'b0;
    pix_addr   = '0;
    pix_data   = '0;
    case (state)
      FETCH: line_req = 1'b1;
      RD: begin
        dmem_rd_en = 1'b1;
        dmem_addr  = pt_addr;
      end
      CMP: begin
        dmem_addr = pt_addr;
        if (closer) begin
          dmem_wr_en = 1'b1;
          dmem_wdata = pt.z;
          pix_we     = 1'b1;
          pix_addr   = pt_addr;
          pix_data   = color_q;
        end
      end
      EOC: line_eoc = 1'b1;
      FIN: done = 1'b1;
      CLR: begin
        dmem_wr_en = 1'b1;
        dmem_wdata = CLEAR_DEPTH;
        dmem_addr  = ADDR_W'(clr_cnt);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_zbuf_depth_test.sv
// tb_zbuf_depth_test: drives zbuf_depth_test with a behavioural line
// generator and depth RAM, and predicts every pixel write from a
// screen-level depth array updated with the "strictly closer wins" rule.
module tb_zbuf_depth_test;
  import zbuf_pkg::*;

  logic        clk, rst, start, clear;
  logic [7:0]  color_in;
  logic        busy, done, line_init, line_req, line_ack, line_eol, line_eoc;
  logic [23:0] point_in;
  logic [15:0] dmem_addr;
  logic        dmem_rd_en, dmem_wr_en;
  logic [7:0]  dmem_rdata, dmem_wdata;
  logic        pix_we;
  logic [15:0] pix_addr;
  logic [7:0]  pix_data;
  logic [15:0] pix_count;

  int compared   = 0;
  int mismatched = 0;

  // Depth RAM model plus a poke port so the bench can preload depths.
  logic [7:0]  mem [0:65535];
  logic        poke_en;
  logic [15:0] poke_addr;
  logic [7:0]  poke_val;

  // Screen-level expected depth.
  logic [7:0]  ref_depth [0:65535];

  point_t pts_q[$];
  bit     eol_q[$];

  zbuf_depth_test #(.COLOR_W(8), .CLEAR_DEPTH(8'hFF), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .color_in(color_in),
    .busy(busy), .done(done), .line_init(line_init), .line_req(line_req),
    .line_ack(line_ack), .line_eol(line_eol), .line_eoc(line_eoc),
    .point_in(point_in), .dmem_addr(dmem_addr), .dmem_rd_en(dmem_rd_en),
    .dmem_rdata(dmem_rdata), .dmem_wr_en(dmem_wr_en), .dmem_wdata(dmem_wdata),
    .pix_we(pix_we), .pix_addr(pix_addr), .pix_data(pix_data),
    .pix_count(pix_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dmem_rd_en) dmem_rdata = mem[dmem_addr];
    if (dmem_wr_en) mem[dmem_addr] = dmem_wdata;
    if (poke_en) mem[poke_addr] = poke_val;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_line"}, {line_init, line_req, line_eoc}, 0);
    check({tag, "_strobes"}, {dmem_rd_en, dmem_wr_en, pix_we}, 0);
    check({tag, "_addrs"}, {dmem_addr, pix_addr}, 0);
    check({tag, "_data"}, {dmem_wdata, pix_data}, 0);
    check({tag, "_pixcnt"}, pix_count, 0);
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] v);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_val = v;
    @(negedge clk);
    poke_en = 1'b0;
    ref_depth[a] = v;
  endtask

  task automatic add_pt(input int x, input int y, input int z, input bit eol);
    point_t p;
    p.x = 8'(x); p.y = 8'(y); p.z = 8'(z);
    pts_q.push_back(p);
    eol_q.push_back(eol);
  endtask

  task automatic run_clear();
    int wr_cnt = 0, bad = 0, pixw = 0, seen_done = 0;
    @(negedge clk);
    clear = 1'b1; start = 1'b1;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    for (int c = 0; c < 66000; c++) begin
      if (dmem_wr_en) begin
        if (dmem_addr !== 16'(wr_cnt) || dmem_wdata !== 8'hFF) bad++;
        wr_cnt++;
      end
      if (pix_we || line_init || dmem_rd_en) bad++;
      if (done) begin seen_done = 1; break; end
      @(negedge clk);
    end
    check("clr_writes", wr_cnt, 65536);
    check("clr_seq_errors", bad, 0);
    check("clr_pix", pixw, 0);
    check("clr_done", seen_done, 1);
    @(negedge clk);
    check("clr_busy_after", busy, 0);
    check("clr_done_once", done, 0);
    for (int a = 0; a < 65536; a++) ref_depth[a] = 8'hFF;
  endtask

  // Rasterises pts_q/eol_q. big_stall holds ack for 9 cycles after the first
  // point so FETCH sits stalled for at least 7 cycles. abort resets the DUT
  // during the CMP cycle of the first point.
  task automatic run_line(input string tag, input logic [7:0] col, input bit big_stall, input bit abort);
    logic [15:0] exp_addr[$], obs_addr[$];
    logic [7:0]  exp_z[$], obs_z[$], obs_col[$];
    int n = pts_q.size();
    int idx = 0, ack_cnt, cycles = 0, eoc_seen = 0, init_seen = 0, stall_cnt = 0;
    bit saw_done = 0, hold_prev = 0, rd_seen = 0, latch;
    logic [15:0] a;

    if (!abort) begin
      foreach (pts_q[i]) begin
        a = {pts_q[i].y, pts_q[i].x};
        if (pts_q[i].z < ref_depth[a]) begin
          exp_addr.push_back(a);
          exp_z.push_back(pts_q[i].z);
          ref_depth[a] = pts_q[i].z;
        end
      end
    end

    @(negedge clk);
    color_in = col; start = 1'b1; line_ack = 1'b0;
    point_in = pts_q[0]; line_eol = eol_q[0];
    @(negedge clk);
    start = 1'b0;
    ack_cnt = 1 + int'($urandom_range(0, 2));

    while (!saw_done && cycles < 400) begin
      if (line_init) init_seen++;
      if (line_eoc) eoc_seen++;
      if (pix_we) begin
        obs_addr.push_back(pix_addr);
        obs_z.push_back(dmem_wdata);
        obs_col.push_back(pix_data);
        check({tag, "_wr_pair"}, {dmem_wr_en, dmem_addr}, {1'b1, pix_addr});
      end
      if (hold_prev) begin
        stall_cnt++;
        check({tag, "_stall_req"}, line_req, 1);
        check({tag, "_stall_noram"}, {dmem_rd_en, dmem_wr_en}, 0);
      end
      if (done) saw_done = 1;
      if (abort && rd_seen) begin
        rst = 1'b0;
        @(negedge clk);
        check_quiet({tag, "_abort"});
        rst = 1'b1; line_ack = 1'b0;
        return;
      end
      if (abort && dmem_rd_en) rd_seen = 1;
      if (!saw_done) begin
        line_ack = (ack_cnt > 0);
        if (ack_cnt > 0) ack_cnt--;
        point_in = pts_q[(idx < n) ? idx : n - 1];
        line_eol = eol_q[(idx < n) ? idx : n - 1];
        hold_prev = line_req && line_ack;
        latch = line_req && !line_ack && (idx < n);
        @(negedge clk);
        cycles++;
        if (latch) begin
          idx++;
          ack_cnt = (big_stall && idx == 1) ? 9 : int'($urandom_range(0, 2));
        end
      end
    end
    line_ack = 1'b0;

    check({tag, "_done"}, saw_done, 1);
    check({tag, "_init_once"}, init_seen, 1);
    check({tag, "_eoc_once"}, eoc_seen, 1);
    check({tag, "_pix_count"}, pix_count, exp_addr.size());
    check({tag, "_nwrites"}, obs_addr.size(), exp_addr.size());
    if (big_stall) check({tag, "_stall_len_ge7"}, stall_cnt >= 7, 1);
    foreach (obs_addr[i]) begin
      if (i < exp_addr.size()) begin
        check({tag, "_waddr"}, obs_addr[i], exp_addr[i]);
        check({tag, "_wz"}, obs_z[i], exp_z[i]);
        check({tag, "_wcol"}, obs_col[i], col);
      end
    end
    @(negedge clk);
    check({tag, "_idle_after"}, {busy, done}, 0);
  endtask

  task automatic simple_line(input int y, input int z);
    pts_q.delete(); eol_q.delete();
    for (int x = 0; x < 4; x++) add_pt(x, y, z, 0);
    add_pt(3, y, z, 1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; clear = 1'b0; color_in = '0;
    line_ack = 1'b0; line_eol = 1'b0; point_in = '0;
    poke_en = 1'b0; poke_addr = '0; poke_val = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b1;

    run_clear();

    simple_line(0, 10);
    run_line("line", 8'h5A, 0, 0);

    poke(16'd0, 8'hFF); poke(16'd1, 8'hFF); poke(16'd2, 8'd5); poke(16'd3, 8'hFF);
    simple_line(0, 10);
    run_line("occl", 8'hC3, 0, 0);

    simple_line(0, 10);
    run_line("equal", 8'h77, 0, 0);

    pts_q.delete(); eol_q.delete();
    add_pt(0, 1, 20, 0); add_pt(1, 1, 20, 0); add_pt(2, 1, 20, 0); add_pt(2, 1, 20, 1);
    run_line("stall", 8'h11, 1, 0);

    poke({8'd50, 8'd0}, 8'd0);
    pts_q.delete(); eol_q.delete();
    add_pt(0, 50, 0, 0); add_pt(0, 50, 0, 1);
    run_line("zero", 8'h22, 0, 0);

    for (int l = 0; l < 6; l++) begin
      int np = 2 + int'($urandom_range(0, 3));
      pts_q.delete(); eol_q.delete();
      for (int i = 0; i < np; i++)
        add_pt(int'($urandom_range(0, 7)), 10 + int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 0);
      add_pt(pts_q[np-1].x, pts_q[np-1].y, pts_q[np-1].z, 1);
      run_line("rand", 8'($urandom), 0, 0);
    end

    simple_line(100, 7);
    run_line("abort", 8'h44, 0, 1);
    simple_line(200, 9);
    run_line("post_abort", 8'h99, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
